// File: rtl/sd_pkg.sv
// Shared SD-card subsystem definitions: cache geometry and the scanner
// state encoding. Also used by the SD reader and the SD top level.
// No ports.
package sd_pkg;

  localparam int unsigned CACHE_ADDR_W = 8;
  localparam int unsigned CACHE_DATA_W = 16;
  localparam int unsigned CSUM_W       = 16;

  // Scanner FSM encoding (kept as plain constants for the legacy top level)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_DWELL = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Running checksum step, modulo 2^CSUM_W
  function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                 input logic [CSUM_W-1:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/sd_cache_scanner_if.sv
// Bundle between the cache scanner and its surroundings: control inputs,
// cache port-B read bus and the LED-driver / checksum outputs.
// Signals:
//   fill_done, manual, step, pause : scan control into the scanner
//   ram_addr / ram_data             : cache port-B read (data 1 clock after addr)
//   disp_data, disp_addr, disp_valid: word currently presented to the LEDs
//   checksum, sum_valid, busy       : pass checksum and scanner status
// Modports: master = environment side, slave = scanner side.
interface sd_cache_scanner_if
  import sd_pkg::*;
#(
  parameter int unsigned ADDR_W = CACHE_ADDR_W,
  parameter int unsigned DATA_W = CACHE_DATA_W
) ();

  logic              fill_done;
  logic              manual;
  logic              step;
  logic              pause;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] disp_data;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [CSUM_W-1:0] checksum;
  logic              sum_valid;
  logic              busy;

  modport master (
    output fill_done, manual, step, pause, ram_data,
    input  ram_addr, disp_data, disp_addr, disp_valid, checksum, sum_valid, busy
  );

  modport slave (
    input  fill_done, manual, step, pause, ram_data,
    output ram_addr, disp_data, disp_addr, disp_valid, checksum, sum_valid, busy
  );

endinterface

// File: rtl/sd_dwell_timer.sv
// Dwell timing for the cache scanner: counts display clocks in auto mode,
// detects step rising edges for manual mode and gates both with pause.
// Ports:
//   clk50, reset  : board clock, synchronous active-high reset
//   load_i        : restart the dwell count at 0 (asserted in LATCH)
//   run_i         : scanner is in DWELL; counting/advance enabled
//   manual_i      : 1 = advance on step edge, 0 = advance on count expiry
//   step_i        : synchronised, debounced step button level
//   pause_i       : freeze count and suppress advance
//   advance_c_o   : combinational advance request for the current cycle
module sd_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 50000000
) (
  input  logic clk50,
  input  logic reset,
  input  logic load_i,
  input  logic run_i,
  input  logic manual_i,
  input  logic step_i,
  input  logic pause_i,
  output logic advance_c_o
);

  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q;
  logic             step_rise_c;

  // Count / advance decision; a step edge seen while paused is simply lost
  always_comb begin
    cnt_d       = cnt_q;
    advance_c_o = 1'b0;
    step_rise_c = step_i & ~step_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (run_i && !pause_i) begin
      if (manual_i) begin
        advance_c_o = step_rise_c;
      end else if (cnt_q == CNT_LAST) begin
        advance_c_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and step edge register (the latter tracks step every cycle)
  always_ff @(posedge clk50) begin
    if (reset) begin
      cnt_q  <= '0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_i;
    end
  end

endmodule

// File: rtl/sd_cache_scanner.sv
// Sequential reader of the SD temp cache (port B). After fill_done it walks
// addresses 0..LAST_ADDR, holds each word on the LED driver for a dwell
// period (or until a manual step) and checksums the first pass.
// Ports:
//   clk50, reset : board clock, synchronous active-high reset
//   bus (slave)  : control inputs, cache read bus, display and checksum outputs
module sd_cache_scanner
  import sd_pkg::*;
#(
  parameter int unsigned ADDR_W       = CACHE_ADDR_W,
  parameter int unsigned DATA_W       = CACHE_DATA_W,
  parameter int unsigned LAST_ADDR    = 255,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned WRAP         = 1
) (
  input  logic         clk50,
  input  logic         reset,
  sd_cache_scanner_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CSUM_W-1:0] acc_q, acc_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic              disp_valid_q, disp_valid_d;
  logic [CSUM_W-1:0] checksum_q, checksum_d;
  logic              sum_valid_q, sum_valid_d;
  logic              busy_q, busy_d;

  logic              advance_c;
  logic              last_c;
  logic [CSUM_W-1:0] acc_next_c;

  sd_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk50      (clk50),
    .reset      (reset),
    .load_i     (state_q == ST_LATCH),
    .run_i      (state_q == ST_DWELL),
    .manual_i   (bus.manual),
    .step_i     (bus.step),
    .pause_i    (bus.pause),
    .advance_c_o(advance_c)
  );

  assign last_c     = (addr_q == ADDR_LAST);
  assign acc_next_c = csum_add(acc_q, CSUM_W'(bus.ram_data));

  // Next-state and registered-output logic; fill_done overrides every state
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    acc_d        = acc_q;
    first_d      = first_q;
    ram_addr_d   = ram_addr_q;
    disp_data_d  = disp_data_q;
    disp_addr_d  = disp_addr_q;
    disp_valid_d = disp_valid_q;
    checksum_d   = checksum_q;
    sum_valid_d  = sum_valid_q;

    if (bus.fill_done) begin
      // Restart: old word stays on display until the next LATCH
      state_d     = ST_FETCH;
      addr_d      = '0;
      acc_d       = '0;
      first_d     = 1'b1;
      sum_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ram_addr_d = '0;
        end
        ST_FETCH: begin
          ram_addr_d = addr_q;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          state_d = ST_LATCH;
        end
        ST_LATCH: begin
          disp_data_d  = bus.ram_data;
          disp_addr_d  = addr_q;
          disp_valid_d = 1'b1;
          if (first_q) begin
            acc_d = acc_next_c;
            if (last_c) begin
              checksum_d  = acc_next_c;
              sum_valid_d = 1'b1;
            end
          end
          state_d = ST_DWELL;
        end
        ST_DWELL: begin
          if (advance_c) begin
            if (!last_c) begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end else if (WRAP != 0) begin
              // Later passes only refresh the display, never the checksum
              addr_d  = '0;
              first_d = 1'b0;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      acc_q        <= '0;
      first_q      <= 1'b0;
      ram_addr_q   <= '0;
      disp_data_q  <= '0;
      disp_addr_q  <= '0;
      disp_valid_q <= 1'b0;
      checksum_q   <= '0;
      sum_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      acc_q        <= acc_d;
      first_q      <= first_d;
      ram_addr_q   <= ram_addr_d;
      disp_data_q  <= disp_data_d;
      disp_addr_q  <= disp_addr_d;
      disp_valid_q <= disp_valid_d;
      checksum_q   <= checksum_d;
      sum_valid_q  <= sum_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_addr  = disp_addr_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.checksum   = checksum_q;
  assign bus.sum_valid  = sum_valid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sd_cache_scanner.sv
// Directed bench for sd_cache_scanner: one instance without wrap (basic scan,
// pause, manual step, reset) and one with wrap (checksum overflow, restart).
module tb_sd_cache_scanner;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] mem0 [4];
  logic [15:0] mem1 [4];

  always #5 clk = ~clk;

  sd_cache_scanner_if if0 ();
  sd_cache_scanner_if if1 ();

  sd_cache_scanner #(
    .LAST_ADDR(3), .DWELL_CYCLES(4), .WRAP(0)
  ) dut0 (
    .clk50(clk), .reset(rst0), .bus(if0)
  );

  sd_cache_scanner #(
    .LAST_ADDR(3), .DWELL_CYCLES(4), .WRAP(1)
  ) dut1 (
    .clk50(clk), .reset(rst1), .bus(if1)
  );

  // Synchronous-read cache models: data one clock after the address
  always @(posedge clk) begin
    if0.ram_data <= mem0[if0.ram_addr[1:0]];
    if1.ram_data <= mem1[if1.ram_addr[1:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Display triple packed as {valid, addr, data}
  function automatic logic [31:0] pk(input logic v, input logic [7:0] a, input logic [15:0] d);
    return {7'd0, v, a, d};
  endfunction

  function automatic logic [31:0] st0();
    return {14'd0, if0.checksum, if0.sum_valid, if0.busy};
  endfunction

  function automatic logic [31:0] st1();
    return {14'd0, if1.checksum, if1.sum_valid, if1.busy};
  endfunction

  initial begin
    mem0[0] = 16'h0001; mem0[1] = 16'h0010; mem0[2] = 16'h0100; mem0[3] = 16'h1000;
    mem1[0] = 16'hFFFF; mem1[1] = 16'hFFFF; mem1[2] = 16'h0003; mem1[3] = 16'h0000;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.fill_done = 1'b0; if0.manual = 1'b0; if0.step = 1'b0; if0.pause = 1'b0;
    if1.fill_done = 1'b0; if1.manual = 1'b0; if1.step = 1'b0; if1.pause = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_disp", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), 32'd0);
    check("rst_stat", st0(), 32'd0);
    check("rst_raddr", 32'(if0.ram_addr), 32'd0);
    rst0 = 1'b0;
    tick();

    // Basic auto scan, WRAP=0
    if0.fill_done = 1'b1; tick(); if0.fill_done = 1'b0;
    check("start_busy", {31'd0, if0.busy}, 32'd1);
    check("start_novalid", {31'd0, if0.disp_valid}, 32'd0);
    tick(); tick();
    check("lat_novalid", {31'd0, if0.disp_valid}, 32'd0);
    tick();
    check("first_word", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd0, 16'h0001));
    for (int i = 1; i < 4; i++) begin
      repeat (6) tick();
      check("word_hold", pk(if0.disp_valid, if0.disp_addr, if0.disp_data),
            pk(1'b1, 8'(i - 1), mem0[i - 1]));
      tick();
      check("word_next", pk(if0.disp_valid, if0.disp_addr, if0.disp_data),
            pk(1'b1, 8'(i), mem0[i]));
      if (i < 3) check("sum_pending", {31'd0, if0.sum_valid}, 32'd0);
    end
    check("sum_1111", st0(), {14'd0, 16'h1111, 1'b1, 1'b1});
    repeat (3) tick();
    check("last_dwell_busy", {31'd0, if0.busy}, 32'd1);
    tick();
    check("done_stat", st0(), {14'd0, 16'h1111, 1'b1, 1'b0});
    repeat (5) tick();
    check("done_hold", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd3, 16'h1000));

    // Pause mid-dwell on address 0
    if0.fill_done = 1'b1; tick(); if0.fill_done = 1'b0;
    check("restart_sumclr", st0(), {14'd0, 16'h1111, 1'b0, 1'b1});
    check("restart_oldword", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd3, 16'h1000));
    repeat (3) tick();
    check("p_word0", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd0, 16'h0001));
    tick(); tick();
    if0.pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("pause_hold", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd0, 16'h0001));
    end
    if0.pause = 1'b0;
    repeat (4) tick();
    check("post_pause_hold", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd0, 16'h0001));
    tick();
    check("post_pause_adv", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd1, 16'h0010));

    // Manual stepping
    if0.manual = 1'b1;
    repeat (100) tick();
    check("manual_hold", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd1, 16'h0010));
    if0.step = 1'b1;
    repeat (3) tick();
    check("step_pre", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd1, 16'h0010));
    tick();
    check("step_adv", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd2, 16'h0100));
    repeat (6) tick();
    check("step_held_once", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd2, 16'h0100));
    if0.step = 1'b0; tick(); tick();
    if0.step = 1'b1;
    repeat (4) tick();
    check("step_adv2", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd3, 16'h1000));
    check("step_sum", st0(), {14'd0, 16'h1111, 1'b1, 1'b1});
    if0.step = 1'b0; tick();
    check("step_busy", {31'd0, if0.busy}, 32'd1);
    if0.step = 1'b1; tick();
    check("step_done", {31'd0, if0.busy}, 32'd0);
    if0.step = 1'b0; if0.manual = 1'b0;

    // Reset during DWELL at address 1
    if0.fill_done = 1'b1; tick(); if0.fill_done = 1'b0;
    repeat (3) tick();
    repeat (7) tick();
    check("r_word1", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd1, 16'h0010));
    tick();
    rst0 = 1'b1; tick();
    check("midrst_disp", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), 32'd0);
    check("midrst_stat", st0(), 32'd0);
    rst0 = 1'b0; tick();
    check("midrst_idle", {23'd0, if0.ram_addr, if0.busy}, 32'd0);
    if0.fill_done = 1'b1; tick(); if0.fill_done = 1'b0;
    repeat (3) tick();
    check("rescan_word0", pk(if0.disp_valid, if0.disp_addr, if0.disp_data), pk(1'b1, 8'd0, 16'h0001));
    check("rescan_nosum", {31'd0, if0.sum_valid}, 32'd0);

    // Wrapping instance: checksum overflow and restart mid-pass
    check("rst1_stat", st1(), 32'd0);
    rst1 = 1'b0; tick();
    if1.fill_done = 1'b1; tick(); if1.fill_done = 1'b0;
    repeat (3) tick();
    check("w_word0", pk(if1.disp_valid, if1.disp_addr, if1.disp_data), pk(1'b1, 8'd0, 16'hFFFF));
    for (int i = 1; i < 4; i++) begin
      repeat (7) tick();
      check("w_word", pk(if1.disp_valid, if1.disp_addr, if1.disp_data), pk(1'b1, 8'(i), mem1[i]));
    end
    check("w_sum", st1(), {14'd0, 16'h0001, 1'b1, 1'b1});
    repeat (7) tick();
    check("w_wrap", pk(if1.disp_valid, if1.disp_addr, if1.disp_data), pk(1'b1, 8'd0, 16'hFFFF));
    check("w_wrap_stat", st1(), {14'd0, 16'h0001, 1'b1, 1'b1});
    for (int i = 1; i < 4; i++) begin
      repeat (7) tick();
      check("w2_word", pk(if1.disp_valid, if1.disp_addr, if1.disp_data), pk(1'b1, 8'(i), mem1[i]));
    end
    check("w2_sum_kept", st1(), {14'd0, 16'h0001, 1'b1, 1'b1});
    repeat (21) tick();
    check("w3_addr2", pk(if1.disp_valid, if1.disp_addr, if1.disp_data), pk(1'b1, 8'd2, 16'h0003));
    tick();
    if1.fill_done = 1'b1; tick(); if1.fill_done = 1'b0;
    check("fd_sumdrop", st1(), {14'd0, 16'h0001, 1'b0, 1'b1});
    check("fd_oldword", pk(if1.disp_valid, if1.disp_addr, if1.disp_data), pk(1'b1, 8'd2, 16'h0003));
    tick(); tick();
    check("fd_oldword2", pk(if1.disp_valid, if1.disp_addr, if1.disp_data), pk(1'b1, 8'd2, 16'h0003));
    tick();
    check("fd_newscan", pk(if1.disp_valid, if1.disp_addr, if1.disp_data), pk(1'b1, 8'd0, 16'hFFFF));
    repeat (21) tick();
    check("fd_sum_again", st1(), {14'd0, 16'h0001, 1'b1, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
